mode_sequencer: RTL and testbench
=================================

MODE_SEQUENCER -- requirements
Module: mode_sequencer

Interface
REQ-001 SHALL have parameter BEATS, default 4; load beats per transaction, legal range 1..255.
REQ-002 SHALL have parameter TIMEOUT, default 16; WAITE-state watchdog limit in cycles, legal range 1..255.
REQ-003 SHALL have port clk  input  1  sole clock; all logic on its rising edge.
REQ-004 SHALL have port resetN  input  1  synchronous, active-low reset.
REQ-005 SHALL have port start  input  1  transaction request, sampled each cycle.
REQ-006 SHALL have port abort  input  1  cancel an in-flight transaction.
REQ-007 SHALL have port ready_in  input  1  datapath ready; one accepted beat per high cycle in LOAD.
REQ-008 SHALL have port mode_control  output  3  datapath mode code.
REQ-009 SHALL have port sm_out  output  1  high only in IDLE.
REQ-010 SHALL have port busy  output  1  high in WAITE and LOAD.
REQ-011 SHALL have port done  output  1  one-cycle completion pulse.
REQ-012 SHALL have port beat_cnt  output  8  beats accepted in the current or last transaction.
REQ-013 SHALL have port timeout_err  output  1  one-cycle watchdog pulse.

Function
REQ-014 SHALL implement a registered Moore FSM with states IDLE, WAITE, LOAD, DONE; all outputs decoded from the state register and counters, with no combinational path from inputs to outputs.
REQ-015 SHALL drive mode_control with READY=3'b101 in IDLE and WAITE, SET=3'b010 in LOAD, and GO=3'b110 in DONE.
REQ-016 IDLE: start=1 SHALL clear beat_cnt to 0 and move to WAITE next cycle; otherwise remain in IDLE.
REQ-017 WAITE: abort=1 SHALL move to IDLE; else ready_in=1 SHALL move to LOAD; else remain in WAITE.
REQ-018 LOAD: abort=1 SHALL move to IDLE with beat_cnt held; else ready_in=1 SHALL increment beat_cnt; ready_in=0 SHALL stall with beat_cnt held.
REQ-019 LOAD SHALL move to DONE on the cycle the increment makes beat_cnt equal BEATS; beat_cnt SHALL never exceed BEATS.
REQ-020 DONE SHALL assert done for exactly one cycle and return to IDLE unconditionally; beat_cnt SHALL hold BEATS until the next accepted start.
REQ-021 abort SHALL take priority over ready_in; abort SHALL be ignored in IDLE and DONE; start SHALL be ignored outside IDLE.
REQ-022 Minimum latency: start at cycle 0 with ready_in held high SHALL produce done at cycle 2+BEATS.
REQ-023 An unreachable state encoding SHALL recover to IDLE on the next cycle.

Reset
REQ-024 resetN=0 at a clock edge SHALL force IDLE and zero beat_cnt and the watchdog counter, regardless of all other inputs, including mid-transaction.
REQ-025 The cycle after reset, outputs SHALL be: mode_control=3'b101, sm_out=1, busy=0, done=0, beat_cnt=0, timeout_err=0.

Configuration
REQ-026 Macro MODE_SEQ_TIMEOUT_EN defined: a watchdog counter SHALL count consecutive WAITE cycles with ready_in=0 and abort=0; when it reaches TIMEOUT the FSM SHALL move to IDLE, and timeout_err SHALL pulse for one cycle in that first IDLE cycle.
REQ-027 Under MODE_SEQ_TIMEOUT_EN, the watchdog counter SHALL clear on entering WAITE and on any ready_in=1 cycle.
REQ-028 Macro MODE_SEQ_TIMEOUT_EN undefined: WAITE SHALL wait indefinitely, timeout_err SHALL be constant 0, and no watchdog logic SHALL be synthesized.

Verification
REQ-029 BEATS=4, start at cycle 0, ready_in held high -> mode READY,READY,SET x4,GO; done at cycle 6; beat_cnt=4.
REQ-030 BEATS=4, ready_in low for 3 cycles mid-LOAD -> beat_cnt holds, mode stays SET, done delayed by exactly 3 cycles.
REQ-031 abort after 2 accepted beats -> IDLE next cycle, no done pulse, beat_cnt=2, sm_out=1; start while busy has no effect.
REQ-032 resetN=0 for one cycle while in LOAD -> next cycle IDLE, beat_cnt=0, all outputs at reset values.
REQ-033 MODE_SEQ_TIMEOUT_EN, TIMEOUT=16, ready_in held low after start -> IDLE after 16 WAITE cycles with one timeout_err pulse; macro undefined -> busy stays high and timeout_err=0.
REQ-034 BEATS=1, start with ready_in held high -> exactly one LOAD cycle, done at cycle 3.

Source files
------------

// File: rtl/mode_sequencer.sv
// Transaction mode sequencer: IDLE -> WAITE -> LOAD (BEATS beats) -> DONE -> IDLE.
// Latency: start to done is 2+BEATS cycles with ready_in held high; all outputs registered/state-decoded.
// Backpressure: ready_in low stalls WAITE/LOAD; abort cancels an in-flight transaction.
//
// Ports:
//   clk          sole clock, rising edge
//   resetN       synchronous active-low reset
//   start        transaction request (honoured only in IDLE)
//   abort        cancel (honoured only in WAITE and LOAD, wins over ready_in)
//   ready_in     datapath ready; one beat accepted per high cycle in LOAD
//   mode_control READY=101 (IDLE/WAITE), SET=010 (LOAD), GO=110 (DONE)
//   sm_out       high only in IDLE
//   busy         high in WAITE and LOAD
//   done         one-cycle completion pulse (DONE state)
//   beat_cnt     beats accepted in the current or last transaction
//   timeout_err  one-cycle watchdog pulse (constant 0 unless enabled)
//
// Optional feature: define MODE_SEQ_TIMEOUT_EN to build the WAITE watchdog.

module mode_sequencer #(
  parameter int BEATS   = 4,
  parameter int TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       resetN,
  input  logic       start,
  input  logic       abort,
  input  logic       ready_in,
  output logic [2:0] mode_control,
  output logic       sm_out,
  output logic       busy,
  output logic       done,
  output logic [7:0] beat_cnt,
  output logic       timeout_err
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_WAITE = 2'd1;
  localparam logic [1:0] ST_LOAD  = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  localparam logic [2:0] MODE_READY = 3'b101;
  localparam logic [2:0] MODE_SET   = 3'b010;
  localparam logic [2:0] MODE_GO    = 3'b110;

  // Last beat index: the increment from this value completes the transaction.
  localparam logic [7:0] BEAT_LAST = 8'(BEATS - 1);

  // Elaboration-time parameter range checks.
  if (BEATS < 1 || BEATS > 255) begin : g_bad_beats
    $error("mode_sequencer: BEATS out of range 1..255");
  end
  if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_timeout
    $error("mode_sequencer: TIMEOUT out of range 1..255");
  end

  logic [1:0] state_q;
  logic [1:0] state_d;
  logic [7:0] beat_d;
  logic       wd_expire;

  always_comb begin
    state_d = state_q;
    beat_d  = beat_cnt;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_WAITE;
          beat_d  = 8'd0;
        end
      end
      ST_WAITE: begin
        if (abort)         state_d = ST_IDLE;
        else if (ready_in) state_d = ST_LOAD;
        else if (wd_expire) state_d = ST_IDLE;
      end
      ST_LOAD: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else if (ready_in) begin
          beat_d = beat_cnt + 8'd1;
          if (beat_cnt == BEAT_LAST) state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetN) begin
      state_q  <= ST_IDLE;
      beat_cnt <= 8'd0;
    end else begin
      state_q  <= state_d;
      beat_cnt <= beat_d;
    end
  end

`ifdef MODE_SEQ_TIMEOUT_EN
  localparam logic [7:0] WD_LAST = 8'(TIMEOUT - 1);

  logic [7:0] wd_cnt;
  logic       to_q;

  // Expires on the TIMEOUT-th consecutive idle WAITE cycle.
  assign wd_expire = (state_q == ST_WAITE) && !abort && !ready_in && (wd_cnt == WD_LAST);

  always_ff @(posedge clk) begin
    if (!resetN) begin
      wd_cnt <= 8'd0;
      to_q   <= 1'b0;
    end else begin
      to_q <= wd_expire;
      if (state_q == ST_WAITE && !abort && !ready_in && !wd_expire)
        wd_cnt <= wd_cnt + 8'd1;
      else
        wd_cnt <= 8'd0;
    end
  end

  assign timeout_err = to_q;
`else
  assign wd_expire   = 1'b0;
  assign timeout_err = 1'b0;
`endif

  always_comb begin
    mode_control = MODE_READY;
    case (state_q)
      ST_LOAD: mode_control = MODE_SET;
      ST_DONE: mode_control = MODE_GO;
      default: mode_control = MODE_READY;
    endcase
  end

  assign sm_out = (state_q == ST_IDLE);
  assign busy   = (state_q == ST_WAITE) || (state_q == ST_LOAD);
  assign done   = (state_q == ST_DONE);

endmodule

// File: tb/tb_mode_sequencer.sv
// Directed bench for mode_sequencer: vector table for BEATS=4 plus hand sequences
// for the watchdog and a BEATS=1 instance.
module tb_mode_sequencer;

  logic       clk = 1'b0;
  logic       resetN, start, abort, ready_in;
  logic [2:0] mode_control, mode_control1;
  logic       sm_out, busy, done, timeout_err;
  logic       sm_out1, busy1, done1, timeout_err1;
  logic [7:0] beat_cnt, beat_cnt1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mode_sequencer #(.BEATS(4), .TIMEOUT(16)) dut (
    .clk(clk), .resetN(resetN), .start(start), .abort(abort), .ready_in(ready_in),
    .mode_control(mode_control), .sm_out(sm_out), .busy(busy), .done(done),
    .beat_cnt(beat_cnt), .timeout_err(timeout_err)
  );

  mode_sequencer #(.BEATS(1), .TIMEOUT(16)) dut1 (
    .clk(clk), .resetN(resetN), .start(start), .abort(abort), .ready_in(ready_in),
    .mode_control(mode_control1), .sm_out(sm_out1), .busy(busy1), .done(done1),
    .beat_cnt(beat_cnt1), .timeout_err(timeout_err1)
  );

  // Expected state tags used by the vector table.
  localparam int I = 0, W = 1, L = 2, D = 3;

  typedef struct {
    bit       rst_n;
    bit       st;
    bit       ab;
    bit       rd;
    int       exp_state;
    bit [7:0] exp_beat;
  } vec_t;

  vec_t vecs[$];

  // Output bundle {mode, sm_out, busy, done, beat_cnt, timeout_err} required in a given state.
  function automatic logic [14:0] expect_of(int s, logic [7:0] bc, logic to);
    logic [2:0] m;
    case (s)
      L:       m = 3'b010;
      D:       m = 3'b110;
      default: m = 3'b101;
    endcase
    return {m, 1'(s == I), 1'(s == W || s == L), 1'(s == D), bc, to};
  endfunction

  task automatic add(input bit r, input bit s, input bit a, input bit rd,
                     input int es, input bit [7:0] eb);
    vec_t v;
    v.rst_n = r; v.st = s; v.ab = a; v.rd = rd; v.exp_state = es; v.exp_beat = eb;
    vecs.push_back(v);
  endtask

  task automatic drive(input bit r, input bit s, input bit a, input bit rd);
    resetN = r; start = s; abort = a; ready_in = rd;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [14:0] act, input logic [14:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got mode=%b sm=%b busy=%b done=%b beat=%0d to=%b, want mode=%b sm=%b busy=%b done=%b beat=%0d to=%b",
               name, act[14:12], act[11], act[10], act[9], act[8:1], act[0],
               exp[14:12], exp[11], exp[10], exp[9], exp[8:1], exp[0]);
    end
  endtask

  function automatic logic [14:0] outs();
    return {mode_control, sm_out, busy, done, beat_cnt, timeout_err};
  endfunction

  function automatic logic [14:0] outs1();
    return {mode_control1, sm_out1, busy1, done1, beat_cnt1, timeout_err1};
  endfunction

  initial begin
    resetN = 1'b0; start = 1'b0; abort = 1'b0; ready_in = 1'b0;

    // reset
    add(0,0,0,0, I,0);
    // full transaction, ready held high
    add(1,1,0,1, W,0); add(1,0,0,1, L,0); add(1,0,0,1, L,1); add(1,0,0,1, L,2);
    add(1,0,0,1, L,3); add(1,0,0,1, D,4); add(1,0,0,1, I,4); add(1,0,0,0, I,4);
    // three-cycle stall mid-LOAD
    add(1,1,0,0, W,0); add(1,0,0,0, W,0); add(1,0,0,1, L,0); add(1,0,0,1, L,1);
    add(1,0,0,0, L,1); add(1,0,0,0, L,1); add(1,0,0,0, L,1);
    add(1,0,0,1, L,2); add(1,0,0,1, L,3); add(1,0,0,1, D,4); add(1,0,0,1, I,4);
    // abort after two beats; start while busy ignored
    add(1,1,0,1, W,0); add(1,0,0,1, L,0); add(1,0,0,1, L,1); add(1,1,0,1, L,2);
    add(1,0,1,1, I,2); add(1,0,0,0, I,2);
    // abort in WAITE beats ready_in
    add(1,1,0,0, W,0); add(1,0,1,1, I,0);
    // abort ignored in IDLE; reset mid-LOAD
    add(1,1,1,0, W,0); add(1,0,0,0, W,0); add(1,0,0,1, L,0); add(1,0,0,1, L,1);
    add(0,1,0,1, I,0); add(1,0,0,0, I,0);
    // start/abort ignored in DONE; next start clears beat_cnt
    add(1,1,0,1, W,0); add(1,0,0,1, L,0); add(1,0,0,1, L,1); add(1,0,0,1, L,2);
    add(1,0,0,1, L,3); add(1,0,0,1, D,4); add(1,1,1,1, I,4); add(1,1,0,0, W,0);
    add(1,0,1,0, I,0);

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].rst_n, vecs[i].st, vecs[i].ab, vecs[i].rd);
      check($sformatf("vec%0d", i), outs(), expect_of(vecs[i].exp_state, vecs[i].exp_beat, 1'b0));
    end

    // Watchdog: ready_in held low after start.
    drive(0,0,0,0);
    check("wd_reset", outs(), expect_of(I, 8'd0, 1'b0));
    drive(1,1,0,0);
    check("wd_wait0", outs(), expect_of(W, 8'd0, 1'b0));
`ifdef MODE_SEQ_TIMEOUT_EN
    for (int k = 1; k < 16; k++) begin
      drive(1,0,0,0);
      check($sformatf("wd_wait%0d", k), outs(), expect_of(W, 8'd0, 1'b0));
    end
    drive(1,0,0,0);
    check("wd_expire", outs(), expect_of(I, 8'd0, 1'b1));
    drive(1,0,0,0);
    check("wd_pulse_end", outs(), expect_of(I, 8'd0, 1'b0));
`else
    for (int k = 1; k < 21; k++) begin
      drive(1,0,0,0);
      check($sformatf("wd_wait%0d", k), outs(), expect_of(W, 8'd0, 1'b0));
    end
    drive(1,0,1,0);
    check("wd_abort_exit", outs(), expect_of(I, 8'd0, 1'b0));
`endif

    // BEATS=1: exactly one LOAD cycle, done at cycle 3.
    drive(0,0,0,0);
    check("b1_reset", outs1(), expect_of(I, 8'd0, 1'b0));
    drive(1,1,0,1);
    check("b1_c1_wait", outs1(), expect_of(W, 8'd0, 1'b0));
    drive(1,0,0,1);
    check("b1_c2_load", outs1(), expect_of(L, 8'd0, 1'b0));
    drive(1,0,0,1);
    check("b1_c3_done", outs1(), expect_of(D, 8'd1, 1'b0));
    drive(1,0,0,1);
    check("b1_c4_idle", outs1(), expect_of(I, 8'd1, 1'b0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
